overlay_ctrl: RTL and testbench
===============================

Name: overlay_ctrl

Overview:
Sequencer for the PE-array overlay. It streams a program of instructions into the PEs, then runs a configurable number of batches. For each batch it gathers PE_NUM input samples into the input buffer, waits a programmed execution time, pulses the output-buffer load, and collects PE_NUM serialized results. It sits between the host/DMA streams and the overlay top, and drives the overlay's ce, load, din_overlay_v, din_overlay, inst_in_v and inst_in.

Parameters:
PE_NUM, 8, number of PEs; also the samples per batch in and out
DATA_WIDTH, 16, real/imag component width; samples are DATA_WIDTH*2 bits
INST_WIDTH, 64, instruction word width
CNT_W, 16, width of the cycle/count configuration fields
DRAIN_TIMEOUT, 1024, maximum cycles in DRAIN before an error is flagged

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; sampled only in IDLE
cfg_num_inst  in  8  instruction words to load; 0 skips program load
cfg_num_batch  in  CNT_W  batches per run; 0 is treated as 1
cfg_exec_cycles  in  CNT_W  EXEC wait cycles per batch; 0 is treated as 1
s_inst_v  in  1  host instruction valid
s_inst  in  INST_WIDTH  host instruction word
s_inst_rdy  out  1  instruction ready
s_din_v  in  1  host sample valid
s_din  in  DATA_WIDTH*2  host sample
s_din_rdy  out  1  sample ready
ce  out  1  overlay clock enable
load  out  1  one-cycle output-buffer load pulse
din_overlay_v  out  1  sample valid toward overlay
din_overlay  out  DATA_WIDTH*2  sample toward overlay
inst_in_v  out  1  instruction valid toward overlay
inst_in  out  INST_WIDTH  instruction toward overlay
dout_overlay_v  in  1  serialized result valid from overlay
dout_overlay  in  DATA_WIDTH*2  serialized result
m_dout_v  out  1  result valid to host; no backpressure
m_dout  out  DATA_WIDTH*2  result to host
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle pulse when the run completes
err  out  1  sticky drain-timeout flag; cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; all counters are 0.
  - All outputs are 0, except ce, which is 1.
- Configuration: all cfg_* inputs are captured on the start cycle; changes after that are ignored until the next start.
- FSM states: IDLE, INST, DIN, EXEC, LOAD, DRAIN.
- IDLE:
  - start=1 clears err.
  - Next state is INST if cfg_num_inst != 0, otherwise DIN.
- INST:
  - s_inst_rdy=1.
  - Each s_inst_v&&s_inst_rdy cycle registers the word onto inst_in and inst_in_v on the next cycle (1-cycle latency) and increments inst_cnt.
  - When inst_cnt reaches num_inst-1 and a transfer occurs, go to DIN.
- DIN:
  - s_din_rdy=1.
  - Each accepted sample appears on din_overlay/din_overlay_v one cycle later.
  - After the PE_NUM-th acceptance, go to EXEC.
  - A gap in s_din_v holds the state; din_overlay_v=0 during gaps.
- EXEC: counts exec_cycles cycles, then goes to LOAD.
- LOAD:
  - Asserts load=1 for exactly one cycle, then goes to DRAIN.
  - Clears out_cnt and the timeout counter.
- DRAIN:
  - m_dout and m_dout_v are registered copies of dout_overlay and dout_overlay_v (1-cycle latency).
  - out_cnt counts dout_overlay_v.
  - At out_cnt==PE_NUM: if batch_cnt < num_batch-1, increment batch_cnt and go to DIN (instructions persist in the PEs). Otherwise pulse done on the next cycle and go to IDLE.
  - If the timeout counter reaches DRAIN_TIMEOUT first: set err, pulse done, go to IDLE.
- Boundary conditions:
  - dout_overlay_v outside DRAIN is dropped (m_dout_v stays 0).
  - A start that arrives while busy is ignored.
  - At most one of s_inst_rdy and s_din_rdy is high in any cycle.
- Counter widths: the counters do not wrap within a run because their widths cover the config ranges.
- Reset asserted mid-run aborts immediately. No partial state survives, and no done pulse is produced.

Optional Feature:
OVERLAY_CTRL_PERF_EN
- Defined:
  - Adds output perf_cycles[31:0], which counts cycles from the accepted start to done and holds that value until the next start.
  - Adds output perf_stall[31:0], which counts DIN cycles with s_din_v=0.
  - Both are cleared by rst.
- Undefined: neither port nor either counter exists.

Decomposition:
- Shared package overlay_pkg holds:
  - The FSM state encoding constants.
  - PE_NUM, DATA_WIDTH and INST_WIDTH defaults, consistent with the existing parameters.vh values.
  - DRAIN_TIMEOUT.
- One sub-module, ctrl_cnt: a loadable up-counter with clear, enable, and a terminal-count compare. It is instantiated for the inst, sample, exec, out, batch and timeout counts.

Test Plan:
1. Basic run: cfg_num_inst=3, num_batch=1, exec=5, PE_NUM=8 → exactly 3 inst_in_v pulses, 8 din_overlay_v, one load exactly 5 cycles after the 8th sample, 8 m_dout_v, then a done pulse.
2. Program skip and zero-config handling: cfg_num_inst=0, num_batch=0, exec=0 → s_inst_rdy never asserts; behaves as a single batch with exec=1.
3. Multi-batch with input gaps: num_batch=3, s_din_v toggling 50% → 3 load pulses and 24 m_dout_v. With PERF_EN defined, perf_stall equals the number of gap cycles.
4. Drain timeout: the overlay model returns only 5 outputs → after 1024 DRAIN cycles err=1 and done pulses. A following start clears err.
5. Abort and ignored start: rst dropped during EXEC → all outputs are 0 and ce=1 asynchronously, and no done pulse follows. A start issued while busy has no effect on counts.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared definitions for the PE-array overlay sequencer.
// Holds the default geometry of the overlay, the drain timeout and the
// sequencer state encoding.
package overlay_pkg;

   localparam int unsigned PE_NUM_DEF        = 8;
   localparam int unsigned DATA_WIDTH_DEF    = 16;
   localparam int unsigned INST_WIDTH_DEF    = 64;
   localparam int unsigned CNT_W_DEF         = 16;
   localparam int unsigned DRAIN_TIMEOUT_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INST  = 3'd1,
      ST_DIN   = 3'd2,
      ST_EXEC  = 3'd3,
      ST_LOAD  = 3'd4,
      ST_DRAIN = 3'd5
   } ovl_state_t;

endpackage

// File: rtl/overlay_ctrl_if.sv
// Host-side stream bundle of the overlay sequencer.
//   s_inst_v/s_inst/s_inst_rdy : instruction stream host -> sequencer
//   s_din_v/s_din/s_din_rdy    : sample stream host -> sequencer
//   m_dout_v/m_dout            : result stream sequencer -> host (no backpressure)
// master = host side, slave = sequencer side.
interface overlay_ctrl_if
   import overlay_pkg::*;
#(
   parameter int unsigned DATA_W = 2 * DATA_WIDTH_DEF,
   parameter int unsigned INST_W = INST_WIDTH_DEF
);
   logic              s_inst_v;
   logic [INST_W-1:0] s_inst;
   logic              s_inst_rdy;
   logic              s_din_v;
   logic [DATA_W-1:0] s_din;
   logic              s_din_rdy;
   logic              m_dout_v;
   logic [DATA_W-1:0] m_dout;

   modport master (
      output s_inst_v, s_inst, s_din_v, s_din,
      input  s_inst_rdy, s_din_rdy, m_dout_v, m_dout
   );

   modport slave (
      input  s_inst_v, s_inst, s_din_v, s_din,
      output s_inst_rdy, s_din_rdy, m_dout_v, m_dout
   );
endinterface

// File: rtl/overlay_ctrl_cnt.sv
// ctrl_cnt: loadable up-counter with synchronous clear and enable, plus a
// combinational terminal-count compare against tc_val.
//   clr (highest priority) > ld (load ld_val) > en (increment)
//   tc_c = (count == tc_val)
module ctrl_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic [W-1:0] tc_val,
   output logic         tc_c
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     cnt_q <= '0;
      else if (clr) cnt_q <= '0;
      else if (ld)  cnt_q <= ld_val;
      else if (en)  cnt_q <= cnt_q + W'(1);
   end

   assign tc_c = (cnt_q == tc_val);
endmodule

// File: rtl/overlay_ctrl.sv
// overlay_ctrl: sequencer for the PE-array overlay.
// Loads a program into the PEs, then per batch gathers PE_NUM samples,
// waits the programmed execution time, pulses load and collects PE_NUM
// serialized results.
// Ports:
//   clk, rst (async, active-low)
//   start, cfg_num_inst, cfg_num_batch, cfg_exec_cycles : run control, captured on start
//   host (overlay_ctrl_if.slave) : instruction/sample input streams, result output
//   ce, load, din_overlay_v/din_overlay, inst_in_v/inst_in : toward overlay
//   dout_overlay_v/dout_overlay : serialized results from overlay
//   busy, done, err : status
// Optional: OVERLAY_CTRL_PERF_EN adds perf_cycles / perf_stall counters.
module overlay_ctrl
   import overlay_pkg::*;
#(
   parameter int unsigned PE_NUM        = PE_NUM_DEF,
   parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int unsigned INST_WIDTH    = INST_WIDTH_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF,
   parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [7:0]              cfg_num_inst,
   input  logic [CNT_W-1:0]        cfg_num_batch,
   input  logic [CNT_W-1:0]        cfg_exec_cycles,
   overlay_ctrl_if.slave           host,
   output logic                    ce,
   output logic                    load,
   output logic                    din_overlay_v,
   output logic [2*DATA_WIDTH-1:0] din_overlay,
   output logic                    inst_in_v,
   output logic [INST_WIDTH-1:0]   inst_in,
   input  logic                    dout_overlay_v,
   input  logic [2*DATA_WIDTH-1:0] dout_overlay,
   output logic                    busy,
   output logic                    done,
   output logic                    err
`ifdef OVERLAY_CTRL_PERF_EN
   ,
   output logic [31:0]             perf_cycles,
   output logic [31:0]             perf_stall
`endif
);

   localparam int unsigned SMP_W = $clog2(PE_NUM + 1);
   localparam int unsigned TMO_W = $clog2(DRAIN_TIMEOUT + 1);

   ovl_state_t state_q, state_d;

   logic [7:0]       num_inst_q;
   logic [CNT_W-1:0] num_batch_q;
   logic [CNT_W-1:0] exec_q;

   logic s_inst_rdy_q, s_din_rdy_q, m_dout_v_q;
   logic [2*DATA_WIDTH-1:0] m_dout_q;

   logic start_acc, inst_fire, din_fire, dout_take, in_idle;
   logic inst_tc, smp_tc, exec_tc, out_tc, tmo_tc, batch_tc;
   logic drain_last, drain_tmo, batch_adv;

   assign in_idle   = (state_q == ST_IDLE);
   assign start_acc = in_idle && start;
   assign inst_fire = s_inst_rdy_q && host.s_inst_v;
   assign din_fire  = s_din_rdy_q && host.s_din_v;
   // Results are only accepted while draining; anything else is dropped.
   assign dout_take = (state_q == ST_DRAIN) && dout_overlay_v;

   assign host.s_inst_rdy = s_inst_rdy_q;
   assign host.s_din_rdy  = s_din_rdy_q;
   assign host.m_dout_v   = m_dout_v_q;
   assign host.m_dout     = m_dout_q;

   // Run configuration, zero batch/exec counts promoted to one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_inst_q  <= '0;
         num_batch_q <= '0;
         exec_q      <= '0;
      end else if (start_acc) begin
         num_inst_q  <= cfg_num_inst;
         num_batch_q <= (cfg_num_batch == '0) ? CNT_W'(1) : cfg_num_batch;
         exec_q      <= (cfg_exec_cycles == '0) ? CNT_W'(1) : cfg_exec_cycles;
      end
   end

   // Counters; all are held clear while idle.
   ctrl_cnt #(.W(8)) u_inst_cnt (
      .clk(clk), .rst(rst), .clr(in_idle || (inst_fire && inst_tc)), .en(inst_fire),
      .ld(1'b0), .ld_val('0), .tc_val(num_inst_q - 8'd1), .tc_c(inst_tc));

   ctrl_cnt #(.W(SMP_W)) u_smp_cnt (
      .clk(clk), .rst(rst), .clr(in_idle || (din_fire && smp_tc)), .en(din_fire),
      .ld(1'b0), .ld_val('0), .tc_val(SMP_W'(PE_NUM - 1)), .tc_c(smp_tc));

   ctrl_cnt #(.W(CNT_W)) u_exec_cnt (
      .clk(clk), .rst(rst), .clr(in_idle || ((state_q == ST_EXEC) && exec_tc)),
      .en(state_q == ST_EXEC), .ld(1'b0), .ld_val('0),
      .tc_val(exec_q - CNT_W'(1)), .tc_c(exec_tc));

   ctrl_cnt #(.W(SMP_W)) u_out_cnt (
      .clk(clk), .rst(rst), .clr(in_idle || (state_q == ST_LOAD)), .en(dout_take),
      .ld(1'b0), .ld_val('0), .tc_val(SMP_W'(PE_NUM - 1)), .tc_c(out_tc));

   ctrl_cnt #(.W(TMO_W)) u_tmo_cnt (
      .clk(clk), .rst(rst), .clr(in_idle || (state_q == ST_LOAD)),
      .en(state_q == ST_DRAIN), .ld(1'b0), .ld_val('0),
      .tc_val(TMO_W'(DRAIN_TIMEOUT - 1)), .tc_c(tmo_tc));

   ctrl_cnt #(.W(CNT_W)) u_batch_cnt (
      .clk(clk), .rst(rst), .clr(in_idle), .en(batch_adv),
      .ld(1'b0), .ld_val('0), .tc_val(num_batch_q - CNT_W'(1)), .tc_c(batch_tc));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next-state and drain decisions
   always_comb begin
      state_d    = state_q;
      drain_last = 1'b0;
      drain_tmo  = 1'b0;
      batch_adv  = 1'b0;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = (cfg_num_inst != 8'd0) ? ST_INST : ST_DIN;
         ST_INST:  if (inst_fire && inst_tc) state_d = ST_DIN;
         ST_DIN:   if (din_fire && smp_tc) state_d = ST_EXEC;
         ST_EXEC:  if (exec_tc) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_DRAIN;
         ST_DRAIN: begin
            // A completing result wins over a simultaneous timeout.
            if (dout_take && out_tc) begin
               if (batch_tc) begin
                  drain_last = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  batch_adv = 1'b1;
                  state_d   = ST_DIN;
               end
            end else if (tmo_tc) begin
               drain_tmo = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // Status and handshake outputs, decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ce           <= 1'b1;
         s_inst_rdy_q <= 1'b0;
         s_din_rdy_q  <= 1'b0;
         busy         <= 1'b0;
         load         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         ce           <= 1'b1;
         s_inst_rdy_q <= (state_d == ST_INST);
         s_din_rdy_q  <= (state_d == ST_DIN);
         busy         <= (state_d != ST_IDLE);
         load         <= (state_d == ST_LOAD);
         done         <= drain_last || drain_tmo;
         if (start_acc)      err <= 1'b0;
         else if (drain_tmo) err <= 1'b1;
      end
   end

   // Datapath: one-cycle registered forwarding of accepted words.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_in_v     <= 1'b0;
         inst_in       <= '0;
         din_overlay_v <= 1'b0;
         din_overlay   <= '0;
         m_dout_v_q    <= 1'b0;
         m_dout_q      <= '0;
      end else begin
         inst_in_v     <= inst_fire;
         din_overlay_v <= din_fire;
         m_dout_v_q    <= dout_take;
         if (inst_fire) inst_in     <= host.s_inst;
         if (din_fire)  din_overlay <= host.s_din;
         if (dout_take) m_dout_q    <= dout_overlay;
      end
   end

`ifdef OVERLAY_CTRL_PERF_EN
   // Run length (non-idle cycles) and input starvation while gathering samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else if (start_acc) begin
         perf_cycles <= '0;
         perf_stall  <= '0;
      end else begin
         if (!in_idle) perf_cycles <= perf_cycles + 32'd1;
         if ((state_q == ST_DIN) && !host.s_din_v) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_overlay_ctrl.sv
// Randomized bench for overlay_ctrl with a transaction-level reference:
// expected words are queued as the host/overlay hand them over and matched
// in order; run-level counts and latencies come from the run configuration.
module tb_overlay_ctrl;

   logic        clk, rst, start;
   logic [7:0]  cfg_num_inst;
   logic [15:0] cfg_num_batch, cfg_exec_cycles;
   logic        ce, load, din_overlay_v, inst_in_v, busy, done, err;
   logic [31:0] din_overlay, dout_overlay;
   logic [63:0] inst_in;
   logic        dout_overlay_v;
`ifdef OVERLAY_CTRL_PERF_EN
   logic [31:0] perf_cycles, perf_stall;
`endif

   overlay_ctrl_if #(.DATA_W(32), .INST_W(64)) bus ();

   overlay_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_num_inst(cfg_num_inst), .cfg_num_batch(cfg_num_batch),
      .cfg_exec_cycles(cfg_exec_cycles),
      .host(bus),
      .ce(ce), .load(load), .din_overlay_v(din_overlay_v), .din_overlay(din_overlay),
      .inst_in_v(inst_in_v), .inst_in(inst_in),
      .dout_overlay_v(dout_overlay_v), .dout_overlay(dout_overlay),
      .busy(busy), .done(done), .err(err)
`ifdef OVERLAY_CTRL_PERF_EN
      , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks, n_errors;
   int cyc;
   int n_inst, n_din, n_load, n_mdout, n_done, extra, excl, inst_rdy_seen;
   int last_din_cyc, load_cyc, done_cyc, last_mdout_cyc, start_cyc;
   int exp_exec, model_nout, ovl_left;
   bit spur_on, prev_load, prev_done;
   logic [63:0] exp_inst[$];
   logic [31:0] exp_din[$];
   logic [31:0] exp_dout[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: matches forwarded words against queued expectations.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.s_inst_rdy) inst_rdy_seen++;
         if (bus.s_inst_rdy && bus.s_din_rdy) excl++;
         if (inst_in_v) begin
            n_inst++;
            if (exp_inst.size() != 0) check("inst_word", inst_in, exp_inst.pop_front());
            else extra++;
         end
         if (din_overlay_v) begin
            n_din++;
            last_din_cyc = cyc;
            if (exp_din.size() != 0) check("din_word", 64'(din_overlay), 64'(exp_din.pop_front()));
            else extra++;
         end
         if (load) begin
            if (prev_load) extra++;
            else begin
               n_load++;
               load_cyc = cyc;
               check("load_lat", 64'(cyc - last_din_cyc), 64'(exp_exec));
            end
         end
         if (bus.m_dout_v) begin
            n_mdout++;
            last_mdout_cyc = cyc;
            if (exp_dout.size() != 0) check("m_dout", 64'(bus.m_dout), 64'(exp_dout.pop_front()));
            else extra++;
         end
         if (done) begin
            if (prev_done) extra++;
            n_done++;
            done_cyc = cyc;
         end
         prev_load = load;
         prev_done = done;
      end
   end

   // Overlay model: after each load pulse returns model_nout results with random gaps.
   initial begin
      dout_overlay_v = 1'b0;
      dout_overlay   = '0;
      ovl_left       = 0;
      forever begin
         @(posedge clk); #1;
         dout_overlay_v = 1'b0;
         if (load) ovl_left = model_nout;
         else if (ovl_left > 0) begin
            if ($urandom_range(0, 2) != 0) begin
               dout_overlay   = $urandom;
               dout_overlay_v = 1'b1;
               exp_dout.push_back(dout_overlay);
               ovl_left--;
            end
         end else if (spur_on) begin
            dout_overlay   = $urandom;
            dout_overlay_v = 1'b1;
         end
      end
   end

   task automatic clear_model();
      n_inst = 0; n_din = 0; n_load = 0; n_mdout = 0; n_done = 0;
      extra = 0; excl = 0; inst_rdy_seen = 0;
      exp_inst.delete(); exp_din.delete(); exp_dout.delete();
   endtask

   task automatic pulse_start(input int ni, input int nb, input int ne);
      cfg_num_inst    = 8'(ni);
      cfg_num_batch   = 16'(nb);
      cfg_exec_cycles = 16'(ne);
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      // Scramble config: the run must use the captured values.
      cfg_num_inst    = 8'($urandom_range(1, 200));
      cfg_num_batch   = 16'($urandom_range(5, 900));
      cfg_exec_cycles = 16'($urandom_range(50, 900));
   endtask

   // Host driver: offers instructions and samples with random gaps until all accepted.
   task automatic drive_host(input int ni, input int nd, input int gap_pct,
                             input bit poke, output int gaps);
      int il, dl, guard;
      il = ni; dl = nd; guard = 0; gaps = 0;
      while ((il > 0 || dl > 0) && guard < 6000) begin
         logic [63:0] w;
         logic [31:0] d;
         w = {$urandom, $urandom};
         d = $urandom;
         bus.s_inst   = w;
         bus.s_din    = d;
         bus.s_inst_v = (il > 0) && ($urandom_range(0, 99) >= 32'(gap_pct));
         bus.s_din_v  = (dl > 0) && ($urandom_range(0, 99) >= 32'(gap_pct));
         start = poke && (guard == 3);
         @(negedge clk);
         if (bus.s_inst_v && bus.s_inst_rdy) begin exp_inst.push_back(w); il--; end
         if (bus.s_din_v && bus.s_din_rdy) begin exp_din.push_back(d); dl--; end
         else if (bus.s_din_rdy) gaps++;
         @(posedge clk); #1;
         guard++;
      end
      bus.s_inst_v = 1'b0;
      bus.s_din_v  = 1'b0;
      start        = 1'b0;
      if (il > 0 || dl > 0) check("host_timeout", 64'(il + dl), 64'(0));
   endtask

   task automatic do_run(input int ni, input int nb, input int ne, input int nout,
                         input int gap_pct, input bit poke, input bit exp_tmo);
      int nb_e, gaps, g;
      nb_e = (nb == 0) ? 1 : nb;
      clear_model();
      model_nout = nout;
      exp_exec   = (ne == 0) ? 1 : ne;
      pulse_start(ni, nb, ne);
      check("err_clr", 64'(err), 64'(0));
      drive_host(ni, 8 * nb_e, gap_pct, poke, gaps);
      g = 0;
      while (n_done == 0 && g < 4000) begin @(posedge clk); g++; end
      if (n_done == 0) check("done_timeout", 64'(g), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      check("n_inst", 64'(n_inst), 64'(ni));
      check("n_din", 64'(n_din), 64'(8 * nb_e));
      check("n_load", 64'(n_load), 64'(nb_e));
      check("n_mdout", 64'(n_mdout), 64'(exp_tmo ? nout : 8 * nb_e));
      check("n_done", 64'(n_done), 64'(1));
      check("err", 64'(err), 64'(exp_tmo));
      check("busy_end", 64'(busy), 64'(0));
      check("q_left", 64'(exp_inst.size() + exp_din.size() + exp_dout.size()), 64'(0));
      check("extra_evt", 64'(extra), 64'(0));
      check("rdy_excl", 64'(excl), 64'(0));
      if (ni == 0) check("inst_rdy_skip", 64'(inst_rdy_seen), 64'(0));
      if (exp_tmo) check("tmo_lat", 64'(done_cyc - load_cyc), 64'(1025));
      else         check("done_lat", 64'(done_cyc), 64'(last_mdout_cyc));
`ifdef OVERLAY_CTRL_PERF_EN
      check("perf_cycles", 64'(perf_cycles), 64'(done_cyc - start_cyc - 1));
      check("perf_stall", 64'(perf_stall), 64'(gaps));
`endif
   endtask

   initial begin
      int gaps;
      n_checks = 0; n_errors = 0; cyc = 0;
      rst = 1'b0; start = 1'b0;
      cfg_num_inst = '0; cfg_num_batch = '0; cfg_exec_cycles = '0;
      bus.s_inst_v = 1'b0; bus.s_inst = '0; bus.s_din_v = 1'b0; bus.s_din = '0;
      spur_on = 1'b0; model_nout = 8; exp_exec = 1;
      prev_load = 1'b0; prev_done = 1'b0;
      clear_model();
      #12;
      check("rst_ctl", 64'({ce, load, din_overlay_v, inst_in_v, bus.m_dout_v, busy, done,
                            err, bus.s_inst_rdy, bus.s_din_rdy}), 64'(10'h200));
      check("rst_data", 64'(|{din_overlay, inst_in, bus.m_dout}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      do_run(3, 1, 5, 8, 0, 1'b0, 1'b0);   // basic
      do_run(0, 0, 0, 8, 20, 1'b0, 1'b0);  // program skip, zero config
      do_run(2, 3, 7, 8, 50, 1'b0, 1'b0);  // multi-batch with gaps
      do_run(1, 1, 4, 5, 0, 1'b0, 1'b1);   // drain timeout
      do_run(2, 2, 3, 8, 30, 1'b1, 1'b0);  // err cleared, start while busy

      // Overlay results outside DRAIN are dropped.
      clear_model();
      spur_on = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      spur_on = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("spur_mdout", 64'(n_mdout), 64'(0));

      for (int i = 0; i < 3; i++)
         do_run($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 12),
                8, $urandom_range(0, 60), 1'b0, 1'b0);

      // Abort in EXEC with a start attempted while busy.
      clear_model();
      model_nout = 8;
      exp_exec   = 300;
      pulse_start(2, 1, 300);
      drive_host(2, 8, 0, 1'b1, gaps);
      repeat (10) @(posedge clk);
      check("abort_pre_inst", 64'(n_inst), 64'(2));
      check("abort_pre_din", 64'(n_din), 64'(8));
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      check("abort_ctl", 64'({ce, load, din_overlay_v, inst_in_v, bus.m_dout_v, busy, done,
                              err, bus.s_inst_rdy, bus.s_din_rdy}), 64'(10'h200));
      check("abort_data", 64'(|{din_overlay, inst_in, bus.m_dout}), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      clear_model();
      repeat (400) @(posedge clk);
      #1;
      check("abort_done", 64'(n_done), 64'(0));
      check("abort_load", 64'(n_load), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
